fft_mem_sequencer: RTL

//  Controller for the complex intermediate-value RAM of the in-place radix-2 DIT FFT.

---
 rtl/fft_ctrl_pkg.sv | 27 ++
 rtl/fft_mem_sequencer_if.sv | 34 +++
 rtl/addr_delay_line.sv | 31 +++
 rtl/fft_mem_sequencer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/fft_ctrl_pkg.sv
// Shared types and helpers for the FFT RAM sequencer: FSM state encoding and bit reversal.
// Pure declarations: no clocked logic, no latency and no backpressure.
package fft_ctrl_pkg;

    localparam int MAX_ADDR_W = 16;
    localparam int MAX_IDX_W  = $clog2(MAX_ADDR_W);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COMPUTE,
        DRAIN,
        UNLOAD,
        DONE
    } seq_state_e;

    // Reverses the low w bits of v; bits at and above w come back as zero.
    function automatic logic [MAX_ADDR_W-1:0] bitrev(input logic [MAX_ADDR_W-1:0] v, input int w);
        logic [MAX_ADDR_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_ADDR_W; i++) begin
            if (i < w) r[MAX_IDX_W'(w - 1 - i)] = v[MAX_IDX_W'(i)];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_mem_sequencer_if.sv
// Sequencer-side bundle: sample load handshake, RAM read/write ports, twiddle/stage and unload handshake.
// master = sequencer (drives addresses and status); slave = source, RAM, butterfly and sink side.
interface fft_mem_sequencer_if #(
    parameter int ADDR_W  = 4,
    parameter int STAGE_W = 2
);
    logic              start;
    logic              busy;
    logic              done;
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic              rd_is_b;
    logic [ADDR_W-2:0] tw_idx;
    logic [STAGE_W-1:0] stage;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_en;
    logic              ram_sel;
    logic              out_valid;
    logic              out_ready;

    modport master (
        input  start, ld_valid, out_ready,
        output busy, done, ld_ready, rd_addr, rd_valid, rd_is_b, tw_idx,
               stage, wr_addr, wr_en, ram_sel, out_valid
    );

    modport slave (
        output start, ld_valid, out_ready,
        input  busy, done, ld_ready, rd_addr, rd_valid, rd_is_b, tw_idx,
               stage, wr_addr, wr_en, ram_sel, out_valid
    );
endinterface

// File: rtl/addr_delay_line.sv
// Fixed-depth shift register matching read-address/valid to the butterfly pipeline; sync clear.
// Latency DEPTH cycles; no backpressure, shifts every cycle.
module addr_delay_line #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sr_q [DEPTH];
    logic [WIDTH-1:0] sr_d [DEPTH];

    always_comb begin
        sr_d[0] = d_i;
        for (int i = 1; i < DEPTH; i++) sr_d[i] = sr_q[i-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) sr_q[i] <= sr_d[i];
        end
    end

    assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/fft_mem_sequencer.sv
// In-place radix-2 DIT FFT RAM sequencer: bit-reversed load, log2(N) stages, optional unload (FFT_SEQ_UNLOAD_EN).
// Stage = N reads + BFLY_LAT drain cycles; write-back trails reads by BFLY_LAT; only ld_valid/out_ready stall.
module fft_mem_sequencer
    import fft_ctrl_pkg::*;
#(
    parameter int N_POINTS = 16,
    parameter int BFLY_LAT = 3
) (
    input  logic clk,
    input  logic rst,
    fft_mem_sequencer_if.master bus
);

    localparam int ADDR_W  = $clog2(N_POINTS);
    localparam int STAGE_W = $clog2(ADDR_W);
    localparam int DR_W    = $clog2(BFLY_LAT + 1);
    localparam logic [ADDR_W-1:0]  CNT_LAST   = ADDR_W'(N_POINTS - 1);
    localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(ADDR_W - 1);
    localparam logic [DR_W-1:0]    DRAIN_LAST = DR_W'(BFLY_LAT - 1);

    seq_state_e         state_q, state_d;
    logic [ADDR_W-1:0]  ld_cnt_q, ld_cnt_d;
    logic [ADDR_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [DR_W-1:0]    dr_cnt_q, dr_cnt_d;
    logic [STAGE_W-1:0] stage_q, stage_d;

    logic [ADDR_W-1:0]  k_w, span_w, mask_w, op_a_w, op_b_w, rd_addr_w, ld_addr_w;
    logic [ADDR_W-2:0]  tw_w;
    logic [STAGE_W:0]   stage_p1_w;
    logic               rd_valid_w;
    logic [ADDR_W:0]    dl_q;

`ifdef FFT_SEQ_UNLOAD_EN
    logic [ADDR_W-1:0]  out_cnt_q, out_cnt_d;
`else
    logic               unused_out_ready;
    assign unused_out_ready = bus.out_ready;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ld_cnt_q <= '0;
            rd_cnt_q <= '0;
            dr_cnt_q <= '0;
            stage_q  <= '0;
`ifdef FFT_SEQ_UNLOAD_EN
            out_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            ld_cnt_q <= ld_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            dr_cnt_q <= dr_cnt_d;
            stage_q  <= stage_d;
`ifdef FFT_SEQ_UNLOAD_EN
            out_cnt_q <= out_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        ld_cnt_d = ld_cnt_q;
        rd_cnt_d = rd_cnt_q;
        dr_cnt_d = dr_cnt_q;
        stage_d  = stage_q;
`ifdef FFT_SEQ_UNLOAD_EN
        out_cnt_d = out_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = LOAD;
            end
            LOAD: begin
                if (bus.ld_valid) begin
                    if (ld_cnt_q == CNT_LAST) begin
                        ld_cnt_d = '0;
                        state_d  = COMPUTE;
                    end else begin
                        ld_cnt_d = ld_cnt_q + ADDR_W'(1);
                    end
                end
            end
            COMPUTE: begin
                if (rd_cnt_q == CNT_LAST) begin
                    rd_cnt_d = '0;
                    state_d  = DRAIN;
                end else begin
                    rd_cnt_d = rd_cnt_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                if (dr_cnt_q == DRAIN_LAST) begin
                    dr_cnt_d = '0;
                    if (stage_q == STAGE_LAST) begin
                        stage_d = '0;
`ifdef FFT_SEQ_UNLOAD_EN
                        state_d = UNLOAD;
`else
                        state_d = DONE;
`endif
                    end else begin
                        stage_d = stage_q + STAGE_W'(1);
                        state_d = COMPUTE;
                    end
                end else begin
                    dr_cnt_d = dr_cnt_q + DR_W'(1);
                end
            end
`ifdef FFT_SEQ_UNLOAD_EN
            UNLOAD: begin
                if (bus.out_ready) begin
                    if (out_cnt_q == CNT_LAST) begin
                        out_cnt_d = '0;
                        state_d   = DONE;
                    end else begin
                        out_cnt_d = out_cnt_q + ADDR_W'(1);
                    end
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pair index k = rd_cnt/2; the low bit of rd_cnt selects the a or b leg.
    always_comb begin
        k_w        = {1'b0, rd_cnt_q[ADDR_W-1:1]};
        span_w     = ADDR_W'(1) << stage_q;
        mask_w     = span_w - ADDR_W'(1);
        stage_p1_w = {1'b0, stage_q} + (STAGE_W+1)'(1);
        op_a_w     = ((k_w >> stage_q) << stage_p1_w) | (k_w & mask_w);
        op_b_w     = op_a_w | span_w;
        tw_w       = (ADDR_W-1)'((k_w & mask_w) << (ADDR_W - 1 - int'(stage_q)));
    end

    always_comb begin
        rd_valid_w = (state_q == COMPUTE);
        rd_addr_w  = '0;
        if (rd_valid_w) begin
            rd_addr_w = rd_cnt_q[0] ? op_b_w : op_a_w;
        end
`ifdef FFT_SEQ_UNLOAD_EN
        else if (state_q == UNLOAD) begin
            rd_addr_w = out_cnt_q;
        end
`endif
    end

    assign ld_addr_w = ADDR_W'(bitrev(MAX_ADDR_W'(ld_cnt_q), ADDR_W));

    addr_delay_line #(
        .DEPTH (BFLY_LAT),
        .WIDTH (ADDR_W + 1)
    ) u_addr_dly (
        .clk (clk),
        .rst (rst),
        .d_i ({rd_addr_w, rd_valid_w}),
        .q_o (dl_q)
    );

    assign bus.busy     = (state_q != IDLE);
    assign bus.ram_sel  = (state_q != IDLE);
    assign bus.done     = (state_q == DONE);
    assign bus.ld_ready = (state_q == LOAD);
    assign bus.rd_addr  = rd_addr_w;
    assign bus.rd_valid = rd_valid_w;
    assign bus.rd_is_b  = rd_valid_w & rd_cnt_q[0];
    assign bus.tw_idx   = rd_valid_w ? tw_w : '0;
    assign bus.stage    = stage_q;
    // Loading owns the write port; otherwise it belongs to the delayed butterfly write-back.
    assign bus.wr_addr  = (state_q == LOAD) ? ld_addr_w : dl_q[ADDR_W:1];
    assign bus.wr_en    = (state_q == LOAD) ? bus.ld_valid : dl_q[0];
`ifdef FFT_SEQ_UNLOAD_EN
    assign bus.out_valid = (state_q == UNLOAD);
`else
    assign bus.out_valid = 1'b0;
`endif

endmodule
